// File: rtl/w_input_conditioner.sv
// rtl/w_input_conditioner.sv - synchronise, debounce and edge-detect a raw external level into the W input
module w_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic inputClk,
    input  logic inputReset,
    input  logic inputRaw,
    output logic outputW,
    output logic outputRise,
    output logic outputFall,
    output logic outputPending
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] L_DEB = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] L_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] L_ZERO = '0;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_rise_set;
    logic                 w_fall_set;
    logic                 r_w;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_pend;

    always_ff @(posedge inputClk or negedge inputReset) begin
        if (!inputReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= inputRaw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cnt_inc = r_cnt + L_ONE;

    // cnt counts disagreeing samples already accepted in the current PEND run
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = L_ZERO;
        w_rise_set   = 1'b0;
        w_fall_set   = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (r_sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_next_state = ST_HIGH;
                        w_rise_set   = 1'b1;
                    end else begin
                        w_next_state = ST_RISE_PEND;
                        w_next_cnt   = L_ONE;
                    end
                end
            end
            ST_RISE_PEND: begin
                if (!r_sync2) begin
                    w_next_state = ST_LOW;
                end else if (w_cnt_inc == L_DEB) begin
                    w_next_state = ST_HIGH;
                    w_rise_set   = 1'b1;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!r_sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_next_state = ST_LOW;
                        w_fall_set   = 1'b1;
                    end else begin
                        w_next_state = ST_FALL_PEND;
                        w_next_cnt   = L_ONE;
                    end
                end
            end
            ST_FALL_PEND: begin
                if (r_sync2) begin
                    w_next_state = ST_HIGH;
                end else if (w_cnt_inc == L_DEB) begin
                    w_next_state = ST_LOW;
                    w_fall_set   = 1'b1;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_next_state = ST_LOW;
            end
        endcase
    end

    always_ff @(posedge inputClk or negedge inputReset) begin
        if (!inputReset) begin
            r_state <= ST_LOW;
            r_cnt   <= L_ZERO;
            r_w     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_w     <= (w_next_state == ST_HIGH) || (w_next_state == ST_FALL_PEND);
            r_rise  <= w_rise_set;
            r_fall  <= w_fall_set;
            r_pend  <= (w_next_state == ST_RISE_PEND) || (w_next_state == ST_FALL_PEND);
        end
    end

    assign outputW       = r_w;
    assign outputRise    = r_rise;
    assign outputFall    = r_fall;
    assign outputPending = r_pend;

endmodule
